// File: rtl/i2c_cond_pkg.sv
// Shared constants, types and helpers for the I2C pad input conditioner.
// Holds default depths, the debounce counter width helper and channel ids.
package i2c_cond_pkg;

  localparam int I2C_SYNC_STAGES_DEF = 2;
  localparam int I2C_DEBOUNCE_DEF    = 4;

  typedef enum logic [0:0] {
    CH_SCL = 1'b0,
    CH_SDA = 1'b1
  } i2c_chan_e;

  // Wide enough to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One conditioner channel: sync chain, debounce counter, level and pulses.
// Ports: fast_clock, reset (async high), data_in -> data_out, rise/fall/glitch.
module sync_debounce_channel
  import i2c_cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = I2C_SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = I2C_DEBOUNCE_DEF,
  parameter logic RESET_VALUE     = 1'b1
) (
  input  logic fast_clock,
  input  logic reset,
  input  logic data_in,
  output logic data_out,
  output logic rise_out,
  output logic fall_out,
  output logic glitch_out
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic [CW-1:0]          cnt_d, cnt_q;
  logic                   level_d, level_q;
  logic                   rise_d, rise_q;
  logic                   fall_d, fall_q;
  logic                   glitch_d, glitch_q;
  logic                   synced;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], data_in};
    synced   = sync_q[SYNC_STAGES-1];
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        // Enough consecutive differing samples: commit.
        level_d = synced;
        cnt_d   = '0;
        rise_d  = synced;
        fall_d  = ~synced;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (cnt_q != '0) begin
      // Pending change abandoned before it matured.
      cnt_d    = '0;
      glitch_d = 1'b1;
    end
  end

  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q    <= '0;
      level_q  <= RESET_VALUE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign data_out   = level_q;
  assign rise_out   = rise_q;
  assign fall_out   = fall_q;
  assign glitch_out = glitch_q;

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of independent synchroniser/debouncer channels for the I2C pads.
// Ports: fastClock, reset (async high), inputData -> outputData + pulses.
module sync_debounce_bank
  import i2c_cond_pkg::*;
#(
  parameter int                  CHANNELS        = 2,
  parameter int                  SYNC_STAGES     = I2C_SYNC_STAGES_DEF,
  parameter int                  DEBOUNCE_CYCLES = I2C_DEBOUNCE_DEF,
  parameter logic [CHANNELS-1:0] RESET_VALUE     = '1
) (
  input  logic                fastClock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] inputData,
  output logic [CHANNELS-1:0] outputData,
  output logic [CHANNELS-1:0] risingEdge,
  output logic [CHANNELS-1:0] fallingEdge,
  output logic [CHANNELS-1:0] glitchDetected
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_debounce_bank: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_debounce_bank: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_debounce_bank: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_ch (
      .fast_clock(fastClock),
      .reset     (reset),
      .data_in   (inputData[i]),
      .data_out  (outputData[i]),
      .rise_out  (risingEdge[i]),
      .fall_out  (fallingEdge[i]),
      .glitch_out(glitchDetected[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Scoreboard bench for sync_debounce_bank: default and fast configs.
// Reference model works on sample histories, monitor compares every cycle.
module tb_sync_debounce_bank;

  logic       fastClock = 1'b0;
  logic       reset     = 1'b1;
  logic [1:0] inputData = 2'b11;

  logic [1:0] outA, riseA, fallA, glA;
  logic       outB, riseB, fallB, glB;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  bit          in_hist[3][$];
  bit          syn_hist[3][$];
  bit          out_m[3];
  int          s_of[3] = '{2, 2, 3};
  int          d_of[3] = '{4, 4, 1};

  always #5 fastClock = ~fastClock;

  sync_debounce_bank dut_a (
    .fastClock     (fastClock),
    .reset         (reset),
    .inputData     (inputData),
    .outputData    (outA),
    .risingEdge    (riseA),
    .fallingEdge   (fallA),
    .glitchDetected(glA)
  );

  sync_debounce_bank #(
    .CHANNELS       (1),
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(1),
    .RESET_VALUE    (1'b1)
  ) dut_b (
    .fastClock     (fastClock),
    .reset         (reset),
    .inputData     (inputData[0]),
    .outputData    (outB),
    .risingEdge    (riseB),
    .fallingEdge   (fallB),
    .glitchDetected(glB)
  );

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      in_hist[m].delete();
      syn_hist[m].delete();
      out_m[m] = 1'b1;
    end
  endfunction

  // Returns {out, rise, fall, glitch} after one clock edge.
  // The synced sample seen at edge k is the input taken at edge k-S
  // (reset level before that). The output flips when the last D synced
  // samples all differ from it; a glitch is a differing sample followed
  // by a sample equal to the (unchanged) output.
  function automatic logic [3:0] model_step(input int m, input bit x);
    int         n;
    int         idx;
    bit         s;
    bit         all_diff;
    logic [3:0] r;
    in_hist[m].push_back(x);
    n   = in_hist[m].size();
    idx = n - 1 - s_of[m];
    s   = (idx >= 0) ? in_hist[m][idx] : 1'b1;
    syn_hist[m].push_back(s);
    n        = syn_hist[m].size();
    r        = '0;
    all_diff = (n >= d_of[m]);
    if (all_diff) begin
      for (int j = 0; j < d_of[m]; j++)
        if (syn_hist[m][n-1-j] == out_m[m]) all_diff = 1'b0;
    end
    if (all_diff) begin
      out_m[m] = s;
      r[2]     = s;
      r[1]     = ~s;
    end else if (n >= 2 && s == out_m[m] &&
                 syn_hist[m][n-2] != out_m[m]) begin
      r[0] = 1'b1;
    end
    r[3] = out_m[m];
    return r;
  endfunction

  always @(posedge fastClock) begin : model_p
    logic [3:0] a0, a1, b0;
    if (reset) begin
      model_reset();
      exp_q.push_back({2'b11, 6'b000000, 4'b1000});
    end else begin
      a0 = model_step(0, inputData[0]);
      a1 = model_step(1, inputData[1]);
      b0 = model_step(2, inputData[0]);
      exp_q.push_back({a1[3], a0[3], a1[2], a0[2],
                       a1[1], a0[1], a1[0], a0[0], b0});
    end
  end

  always @(posedge fastClock) begin : monitor_p
    logic [11:0] act, exv;
    #1;
    act = {outA, riseA, fallA, glA, outB, riseB, fallB, glB};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t act=%b", $time, act);
    end else begin
      exv = exp_q.pop_front();
      if (act !== exv) begin
        errors++;
        $display("FAIL scoreboard t=%0t act=%b exp=%b", $time, act, exv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exv);
    checks++;
    if (act != exv) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exv);
    end
  endtask

  // Edge index (1-based) at which outA[0] first reads 0, and fall count.
  task automatic measure_a0(output int n, output int fc);
    n  = -1;
    fc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge fastClock);
      #1;
      if (n < 0 && outA[0] == 1'b0) n = c;
      if (fallA[0]) fc++;
    end
  endtask

  task automatic count_a(input int cycles, output int p);
    p = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge fastClock);
      #1;
      p += $countones({riseA, fallA, glA});
    end
  endtask

  task automatic pulse_run(input int low_len, output int code);
    int g, r, f;
    g = 0; r = 0; f = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge fastClock);
      inputData[0] = (c < low_len) ? 1'b0 : 1'b1;
      @(posedge fastClock);
      #1;
      if (glA[0]) g++;
      if (riseA[0]) r++;
      if (fallA[0]) f++;
    end
    code = g * 100 + r * 10 + f;
  endtask

  initial begin : stim
    int n, fc, p, code, e0, e1, first, cnt0, g;
    int hold[2];
    model_reset();
    reset     = 1'b1;
    inputData = 2'b11;
    repeat (3) @(negedge fastClock);
    reset = 1'b0;

    // Async reset while inputs are low and outputs have fallen.
    inputData = 2'b00;
    repeat (10) @(negedge fastClock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outA", int'(outA), 3);
    chk("async_reset_pulsesA", int'({riseA, fallA, glA}), 0);
    chk("async_reset_outB", int'(outB), 1);
    @(negedge fastClock);
    inputData = 2'b11;
    @(negedge fastClock);
    reset = 1'b0;
    count_a(10, p);
    chk("release_no_pulses", p, 0);
    chk("release_out", int'(outA), 3);

    // Clean fall on ch0.
    @(negedge fastClock);
    inputData = 2'b10;
    measure_a0(n, fc);
    chk("clean_fall_latency", n, 6);
    chk("clean_fall_pulses", fc, 1);
    @(negedge fastClock);
    inputData = 2'b11;
    count_a(12, p);
    chk("clean_rise_pulses", p, 1);

    // Short low pulse is rejected; 4-cycle pulse propagates.
    pulse_run(3, code);
    chk("glitch3_g_r_f", code, 100);
    pulse_run(4, code);
    chk("pulse4_g_r_f", code, 11);

    // Ch1 falls one cycle after ch0.
    e0 = -1;
    e1 = -1;
    @(negedge fastClock);
    inputData = 2'b10;
    for (int c = 1; c <= 16; c++) begin
      @(posedge fastClock);
      #1;
      if (fallA[0] && e0 < 0) e0 = c;
      if (fallA[1] && e1 < 0) e1 = c;
      @(negedge fastClock);
      if (c == 1) inputData = 2'b00;
    end
    chk("simul_ch0_edge", e0, 6);
    chk("simul_ch1_edge", e1, 7);
    inputData = 2'b11;
    repeat (12) @(negedge fastClock);

    // Reset in the middle of a count on ch0.
    inputData = 2'b10;
    repeat (3) @(posedge fastClock);
    #2 reset = 1'b1;
    #1;
    chk("midcount_reset_out", int'(outA), 3);
    repeat (2) @(negedge fastClock);
    reset = 1'b0;
    measure_a0(n, fc);
    chk("midcount_release_latency", n, 6);
    chk("midcount_release_pulses", fc, 1);
    @(negedge fastClock);
    inputData = 2'b11;
    repeat (12) @(negedge fastClock);

    // Single-cycle pulse through the 3-stage, no-filter instance.
    first = -1;
    cnt0  = 0;
    g     = 0;
    inputData[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge fastClock);
      #1;
      if (outB == 1'b0) begin
        if (first < 0) first = c;
        cnt0++;
      end
      if (glB) g++;
      @(negedge fastClock);
      inputData[0] = 1'b1;
    end
    chk("fast_cfg_latency", first, 4);
    chk("fast_cfg_low_cycles", cnt0, 1);
    chk("fast_cfg_no_glitch", g, 0);

    // Randomised hold lengths with occasional async reset.
    hold[0] = 0;
    hold[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge fastClock);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          inputData[ch] = 1'($urandom_range(0, 1));
          hold[ch]      = int'($urandom_range(1, 7));
        end else begin
          hold[ch]--;
        end
      end
    end
    @(negedge fastClock);
    reset = 1'b0;
    repeat (5) @(negedge fastClock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
